// File: rtl/mp3_pkg.sv
// Shared types and alias-reduction coefficients for the MP3 decode path.
// Coefficients are Q2.30, rounded to nearest from the decimal butterfly tables.
package mp3_pkg;

    typedef enum logic [1:0] {AA_NONE, AA_SB1, AA_ALL} aa_mode_t;
    typedef enum logic [1:0] {ST_FILL, ST_STREAM, ST_DRAIN} aa_state_t;

    function automatic logic signed [31:0] q30(input real r);
        integer mag;
        mag = $rtoi(((r < 0.0) ? -r : r) * 1073741824.0 + 0.5);
        return (r < 0.0) ? -mag : mag;
    endfunction

    localparam logic signed [31:0] AA_CS [8] = '{
        q30(0.857493), q30(0.881742), q30(0.949629), q30(0.983315),
        q30(0.995518), q30(0.999161), q30(0.999899), q30(0.999993)
    };

    localparam logic signed [31:0] AA_CA [8] = '{
        q30(-0.514496), q30(-0.471732), q30(-0.313377), q30(-0.181913),
        q30(-0.094574), q30(-0.040966), q30(-0.014199), q30(-0.003700)
    };

    // Short blocks skip alias reduction; mixed blocks only touch the long/short seam at sb=1.
    function automatic aa_mode_t aa_mode_sel(input logic ws, input logic [1:0] bt, input logic mixed);
        if (ws && bt == 2'd2) begin
            return mixed ? AA_SB1 : AA_NONE;
        end
        return AA_ALL;
    endfunction

endpackage

// File: rtl/antialias_stream_if.sv
// Line stream into and out of the alias-reduction stage, with granule side info.
interface antialias_stream_if #(
    parameter int W = 32
);
    logic signed [W-1:0] ch1_in;
    logic signed [W-1:0] ch2_in;
    logic                gr_in;
    logic                window_switching_flag_in;
    logic [1:0]          block_type_in;
    logic                mixed_block_flag_in;
    logic                din_v;
    logic                din_ready;
    logic signed [W-1:0] ch1_out;
    logic signed [W-1:0] ch2_out;
    logic                gr_out;
    logic                dout_v;

    modport master (
        output ch1_in, ch2_in, gr_in, window_switching_flag_in, block_type_in,
               mixed_block_flag_in, din_v,
        input  din_ready, ch1_out, ch2_out, gr_out, dout_v
    );

    modport slave (
        input  ch1_in, ch2_in, gr_in, window_switching_flag_in, block_type_in,
               mixed_block_flag_in, din_v,
        output din_ready, ch1_out, ch2_out, gr_out, dout_v
    );
endinterface

// File: rtl/antialias_stream_butterfly.sv
// One alias-reduction butterfly: lo replaces the upper-subband-edge line, hi the lower.
module aa_butterfly #(
    parameter int W = 32
) (
    input  logic signed [W-1:0] bu,
    input  logic signed [W-1:0] bd,
    input  logic signed [W-1:0] cs,
    input  logic signed [W-1:0] ca,
    output logic signed [W-1:0] lo,
    output logic signed [W-1:0] hi
);
    logic signed [2*W-1:0] bu_x, bd_x, cs_x, ca_x;

    assign bu_x = {{W{bu[W-1]}}, bu};
    assign bd_x = {{W{bd[W-1]}}, bd};
    assign cs_x = {{W{cs[W-1]}}, cs};
    assign ca_x = {{W{ca[W-1]}}, ca};

    // Full-precision products, back to Q2.30 by truncating shift; the low W bits wrap.
    assign lo = W'((bu_x * cs_x - bd_x * ca_x) >>> 30);
    assign hi = W'((bd_x * cs_x + bu_x * ca_x) >>> 30);
endmodule

// File: rtl/antialias_stream.sv
// MP3 alias-reduction stage: holds one subband per channel, applies the boundary butterflies
// as lines stream through, and drains the last subband at granule end.
module antialias_stream
    import mp3_pkg::*;
#(
    parameter int W      = 32,
    parameter int NLINES = 576
) (
    input logic               clk,
    input logic               rst,
    antialias_stream_if.slave bus
);
    // state  | meaning
    // FILL   | collecting subband 0, nothing to emit yet
    // STREAM | one buffered line emitted per accepted input
    // DRAIN  | input stalled, last subband emitted over 18 cycles
    localparam logic [4:0] LAST_SB = 5'(NLINES / 18 - 1);

    aa_state_t           state, state_nxt;
    aa_mode_t            mode;
    logic [4:0]          sb, j;
    logic                prev_valid, gr_prev;
    logic                ready, drain, accept, last_j, bfly_en;
    logic signed [W-1:0] cur1 [18];
    logic signed [W-1:0] cur2 [18];
    logic signed [W-1:0] prev1 [18];
    logic signed [W-1:0] prev2 [18];
    logic signed [W-1:0] bu1, bu2, cs, ca, lo1, lo2, hi1, hi2;
    logic signed [W-1:0] ch1_q, ch2_q;
    logic                gr_q, dout_v_q;

    assign accept  = bus.din_v && ready;
    assign last_j  = (j == 5'd17);
    assign bfly_en = (sb != 5'd0) && (j < 5'd8)
                     && ((mode == AA_ALL) || (mode == AA_SB1 && sb == 5'd1));

    always_comb begin
        state_nxt = state;
        ready     = 1'b1;
        drain     = 1'b0;
        case (state)
            ST_FILL: begin
                if (bus.din_v && last_j) state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (bus.din_v && last_j && sb == LAST_SB) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                ready = 1'b0;
                drain = 1'b1;
                if (last_j) state_nxt = ST_FILL;
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FILL;
            mode       <= AA_ALL;
            sb         <= 5'd0;
            j          <= 5'd0;
            prev_valid <= 1'b0;
            gr_prev    <= 1'b0;
            ch1_q      <= '0;
            ch2_q      <= '0;
            gr_q       <= 1'b0;
            dout_v_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            dout_v_q <= 1'b0;
            if (accept) begin
                if (sb == 5'd0 && j == 5'd0) begin
                    mode <= aa_mode_sel(bus.window_switching_flag_in, bus.block_type_in,
                                        bus.mixed_block_flag_in);
                end
                // prev[j] is read before this edge's butterfly write, which only touches prev[17-j].
                if (prev_valid) begin
                    dout_v_q <= 1'b1;
                    ch1_q    <= prev1[j];
                    ch2_q    <= prev2[j];
                    gr_q     <= gr_prev;
                end
                if (last_j) begin
                    j          <= 5'd0;
                    sb         <= (sb == LAST_SB) ? 5'd0 : sb + 5'd1;
                    prev_valid <= 1'b1;
                    gr_prev    <= bus.gr_in;
                end else begin
                    j <= j + 5'd1;
                end
            end else if (drain) begin
                dout_v_q <= 1'b1;
                ch1_q    <= prev1[j];
                ch2_q    <= prev2[j];
                gr_q     <= gr_prev;
                if (last_j) begin
                    j          <= 5'd0;
                    prev_valid <= 1'b0;
                end else begin
                    j <= j + 5'd1;
                end
            end
        end
    end

    assign bu1 = prev1[5'd17 - j];
    assign bu2 = prev2[5'd17 - j];
    assign cs  = AA_CS[j[2:0]];
    assign ca  = AA_CA[j[2:0]];

    aa_butterfly #(.W(W)) u_bfly1 (
        .bu(bu1), .bd(bus.ch1_in), .cs(cs), .ca(ca), .lo(lo1), .hi(hi1)
    );

    aa_butterfly #(.W(W)) u_bfly2 (
        .bu(bu2), .bd(bus.ch2_in), .cs(cs), .ca(ca), .lo(lo2), .hi(hi2)
    );

    // Line buffers carry no reset; prev_valid gates every read of stale content.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (bfly_en) begin
                prev1[5'd17 - j] <= lo1;
                prev2[5'd17 - j] <= lo2;
                cur1[j]          <= hi1;
                cur2[j]          <= hi2;
            end else begin
                cur1[j] <= bus.ch1_in;
                cur2[j] <= bus.ch2_in;
            end
            if (last_j) begin
                for (int k = 0; k < 17; k++) begin
                    prev1[k] <= cur1[k];
                    prev2[k] <= cur2[k];
                end
                prev1[17] <= bus.ch1_in;
                prev2[17] <= bus.ch2_in;
            end
        end
    end

    assign bus.din_ready = ready;
    assign bus.ch1_out   = ch1_q;
    assign bus.ch2_out   = ch2_q;
    assign bus.gr_out    = gr_q;
    assign bus.dout_v    = dout_v_q;
endmodule

// File: tb/tb_antialias_stream.sv
// Scoreboard bench for antialias_stream: an array-based alias-reduction model fills the
// expected queue per granule, a negedge monitor fills the observed queue.
module tb_antialias_stream;
    localparam int W  = 32;
    localparam int NL = 576;

    typedef struct {
        logic signed [W-1:0] c1;
        logic signed [W-1:0] c2;
        logic                g;
        int                  cyc;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    antialias_stream_if #(.W(W)) bus ();
    antialias_stream #(.W(W), .NLINES(NL)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   low_run = 0;
    ent_t expq[$];
    ent_t obsq[$];
    int   ready_runs[$];
    int   in1[NL];
    int   in2[NL];
    int   acc_cyc[NL];
    real  cs_r[8] = '{0.857493, 0.881742, 0.949629, 0.983315, 0.995518, 0.999161, 0.999899, 0.999993};
    real  ca_r[8] = '{-0.514496, -0.471732, -0.313377, -0.181913, -0.094574, -0.040966, -0.014199, -0.003700};
    int   cs_q[8];
    int   ca_q[8];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.dout_v === 1'b1) obsq.push_back(ent_t'{bus.ch1_out, bus.ch2_out, bus.gr_out, cyc});
        if (bus.din_ready === 1'b0) low_run++;
        else if (low_run != 0) begin
            ready_runs.push_back(low_run);
            low_run = 0;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Whole-granule reference: boundaries processed in ascending order on a flat array.
    task automatic model_push(input logic gr, input logic ws, input logic [1:0] bt, input logic mixed);
        int     x1[NL];
        int     x2[NL];
        int     last_sb, lo, hi;
        longint bu, bd;
        x1 = in1;
        x2 = in2;
        if (ws && bt == 2'd2) last_sb = mixed ? 1 : 0;
        else last_sb = 31;
        for (int sb = 1; sb <= last_sb; sb++) begin
            for (int i = 0; i < 8; i++) begin
                lo = 18 * sb - 1 - i;
                hi = 18 * sb + i;
                bu = x1[lo];
                bd = x1[hi];
                x1[lo] = int'((bu * cs_q[i] - bd * ca_q[i]) >>> 30);
                x1[hi] = int'((bd * cs_q[i] + bu * ca_q[i]) >>> 30);
                bu = x2[lo];
                bd = x2[hi];
                x2[lo] = int'((bu * cs_q[i] - bd * ca_q[i]) >>> 30);
                x2[hi] = int'((bd * cs_q[i] + bu * ca_q[i]) >>> 30);
            end
        end
        for (int n = 0; n < NL; n++) expq.push_back(ent_t'{x1[n], x2[n], gr, 0});
    endtask

    task automatic drive_granule(input logic gr, input logic ws, input logic [1:0] bt, input logic mixed,
                                 input int gap_pct, input int count, input bit keep_v);
        int budget;
        bit acc;
        for (int n = 0; n < count; n++) begin
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                bus.din_v = 1'b0;
                @(posedge clk); #1;
            end
            bus.ch1_in = in1[n];
            bus.ch2_in = in2[n];
            bus.gr_in = gr;
            bus.window_switching_flag_in = ws;
            bus.block_type_in = bt;
            bus.mixed_block_flag_in = mixed;
            bus.din_v = 1'b1;
            budget = 0;
            acc = 1'b0;
            while (!acc && budget < 100) begin
                acc = bus.din_ready;
                @(posedge clk); #1;
                budget++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout line %0d: not accepted after %0d cycles, required accept", n, budget);
            end
            acc_cyc[n] = cyc;
        end
        if (!keep_v) bus.din_v = 1'b0;
    endtask

    task automatic wait_obs(input int n, output int got);
        int budget = 0;
        while (obsq.size() < n && budget < 4000) begin
            @(posedge clk);
            budget++;
        end
        repeat (4) @(posedge clk);
        #1;
        got = obsq.size();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 5;
        if (bus.dout_v !== 1'b0) begin errors++; $display("FAIL reset_dout_v: got %b, required 0", bus.dout_v); end
        if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL reset_din_ready: got %b, required 1", bus.din_ready); end
        if (bus.ch1_out !== 0) begin errors++; $display("FAIL reset_ch1_out: got %h, required 0", bus.ch1_out); end
        if (bus.ch2_out !== 0) begin errors++; $display("FAIL reset_ch2_out: got %h, required 0", bus.ch2_out); end
        if (bus.gr_out !== 1'b0) begin errors++; $display("FAIL reset_gr_out: got %b, required 0", bus.gr_out); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_long();
        ent_t e, o;
        int got;
        for (int n = 0; n < NL; n++) begin in1[n] = 0; in2[n] = 0; end
        in1[18] = 32'h4000_0000;
        model_push(1'b0, 1'b0, 2'd0, 1'b0);
        drive_granule(1'b0, 1'b0, 2'd0, 1'b0, 0, NL, 1'b0);
        wait_obs(NL, got);
        checks++;
        if (got != NL) begin errors++; $display("FAIL long_count: got %0d outputs, required %0d", got, NL); end
        for (int k = 0; k < NL && obsq.size() > 0; k++) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks++;
            if (o.c1 !== e.c1 || o.c2 !== e.c2 || o.g !== e.g) begin
                errors++;
                $display("FAIL long_line %0d: got %h/%h/%b, required %h/%h/%b", k, o.c1, o.c2, o.g, e.c1, e.c2, e.g);
            end
            if (k == 17) begin
                checks++;
                if (o.c1 !== -ca_q[0]) begin errors++; $display("FAIL long_out17: got %h, required %h", o.c1, -ca_q[0]); end
            end
            if (k == 18) begin
                checks++;
                if (o.c1 !== cs_q[0]) begin errors++; $display("FAIL long_out18: got %h, required %h", o.c1, cs_q[0]); end
            end
        end
        expq.delete();
        obsq.delete();
    endtask

    task automatic test_short();
        ent_t o;
        int got;
        for (int n = 0; n < NL; n++) begin in1[n] = n; in2[n] = -3 * n; end
        drive_granule(1'b1, 1'b1, 2'd2, 1'b0, 0, NL, 1'b0);
        wait_obs(NL, got);
        checks++;
        if (got != NL) begin errors++; $display("FAIL short_count: got %0d outputs, required %0d", got, NL); end
        if (obsq.size() > 0) begin
            checks++;
            if (obsq[0].cyc != acc_cyc[18]) begin
                errors++;
                $display("FAIL short_latency: first output in cycle %0d, required %0d", obsq[0].cyc, acc_cyc[18]);
            end
        end
        for (int k = 0; k < NL && obsq.size() > 0; k++) begin
            o = obsq.pop_front();
            checks++;
            if (o.c1 !== in1[k] || o.c2 !== in2[k] || o.g !== 1'b1) begin
                errors++;
                $display("FAIL short_line %0d: got %h/%h/%b, required %h/%h/1", k, o.c1, o.c2, o.g, in1[k], in2[k]);
            end
        end
        obsq.delete();
    endtask

    task automatic test_mixed();
        ent_t e, o;
        int got;
        for (int n = 0; n < NL; n++) begin in1[n] = 0; in2[n] = 0; end
        in1[18] = 32'h4000_0000;
        in1[36] = 32'h4000_0000;
        model_push(1'b0, 1'b1, 2'd2, 1'b1);
        drive_granule(1'b0, 1'b1, 2'd2, 1'b1, 0, NL, 1'b0);
        wait_obs(NL, got);
        checks++;
        if (got != NL) begin errors++; $display("FAIL mixed_count: got %0d outputs, required %0d", got, NL); end
        for (int k = 0; k < NL && obsq.size() > 0; k++) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks++;
            if (o.c1 !== e.c1 || o.c2 !== e.c2 || o.g !== e.g) begin
                errors++;
                $display("FAIL mixed_line %0d: got %h/%h/%b, required %h/%h/%b", k, o.c1, o.c2, o.g, e.c1, e.c2, e.g);
            end
            if (k == 17 || k == 18 || k == 35 || k == 36) begin
                checks++;
                if ((k == 17 && o.c1 !== -ca_q[0]) || (k == 18 && o.c1 !== cs_q[0])
                    || (k == 35 && o.c1 !== 0) || (k == 36 && o.c1 !== 32'h4000_0000)) begin
                    errors++;
                    $display("FAIL mixed_impulse line %0d: got %h, required %h", k, o.c1,
                             (k == 17) ? -ca_q[0] : (k == 18) ? cs_q[0] : (k == 35) ? 0 : 32'h4000_0000);
                end
            end
        end
        expq.delete();
        obsq.delete();
    endtask

    task automatic test_back_to_back();
        ent_t e, o;
        int got, first_g1;
        ready_runs.delete();
        for (int g = 0; g < 2; g++) begin
            for (int n = 0; n < NL; n++) begin in1[n] = int'($urandom()); in2[n] = int'($urandom()); end
            model_push(g[0], 1'b0, 2'd0, 1'b0);
            drive_granule(g[0], 1'b0, 2'd0, 1'b0, 0, NL, g == 0);
        end
        wait_obs(2 * NL, got);
        checks++;
        if (got != 2 * NL) begin errors++; $display("FAIL b2b_count: got %0d outputs, required %0d", got, 2 * NL); end
        first_g1 = -1;
        for (int k = 0; k < 2 * NL && obsq.size() > 0; k++) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks++;
            if (o.c1 !== e.c1 || o.c2 !== e.c2 || o.g !== e.g) begin
                errors++;
                $display("FAIL b2b_line %0d: got %h/%h/%b, required %h/%h/%b", k, o.c1, o.c2, o.g, e.c1, e.c2, e.g);
            end
            if (o.g === 1'b1 && first_g1 < 0) first_g1 = k;
        end
        checks++;
        if (first_g1 != NL) begin errors++; $display("FAIL b2b_gr_flip: gr_out first 1 at output %0d, required %0d", first_g1, NL); end
        checks++;
        if (ready_runs.size() != 2) begin
            errors++;
            $display("FAIL b2b_stall_runs: got %0d din_ready low runs, required 2", ready_runs.size());
        end
        foreach (ready_runs[r]) begin
            checks++;
            if (ready_runs[r] != 18) begin
                errors++;
                $display("FAIL b2b_stall_len %0d: din_ready low %0d cycles, required 18", r, ready_runs[r]);
            end
        end
        expq.delete();
        obsq.delete();
    endtask

    task automatic test_random();
        ent_t e, o;
        int got;
        logic       ws_t[3] = '{1'b0, 1'b1, 1'b1};
        logic [1:0] bt_t[3] = '{2'd0, 2'd2, 2'd1};
        logic       mx_t[3] = '{1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 3; c++) begin
            for (int n = 0; n < NL; n++) begin in1[n] = int'($urandom()); in2[n] = int'($urandom()); end
            model_push(c[0], ws_t[c], bt_t[c], mx_t[c]);
            drive_granule(c[0], ws_t[c], bt_t[c], mx_t[c], 40, NL, 1'b0);
            wait_obs(NL, got);
            checks++;
            if (got != NL) begin errors++; $display("FAIL random_count cfg %0d: got %0d outputs, required %0d", c, got, NL); end
            for (int k = 0; k < NL && obsq.size() > 0; k++) begin
                e = expq.pop_front();
                o = obsq.pop_front();
                checks++;
                if (o.c1 !== e.c1 || o.c2 !== e.c2 || o.g !== e.g) begin
                    errors++;
                    $display("FAIL random_line cfg %0d line %0d: got %h/%h/%b, required %h/%h/%b",
                             c, k, o.c1, o.c2, o.g, e.c1, e.c2, e.g);
                end
            end
            expq.delete();
            obsq.delete();
        end
    endtask

    task automatic test_reset_mid();
        ent_t e, o;
        int got;
        for (int n = 0; n < NL; n++) begin in1[n] = int'($urandom()); in2[n] = int'($urandom()); end
        drive_granule(1'b1, 1'b0, 2'd0, 1'b0, 0, 300, 1'b1);
        rst = 1'b1;
        bus.din_v = 1'b0;
        @(posedge clk); #1;
        checks += 2;
        if (bus.dout_v !== 1'b0) begin errors++; $display("FAIL rstmid_dout_v: got %b, required 0", bus.dout_v); end
        if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL rstmid_din_ready: got %b, required 1", bus.din_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
        obsq.delete();
        for (int n = 0; n < NL; n++) begin in1[n] = int'($urandom()); in2[n] = int'($urandom()); end
        model_push(1'b0, 1'b0, 2'd0, 1'b0);
        drive_granule(1'b0, 1'b0, 2'd0, 1'b0, 20, NL, 1'b0);
        wait_obs(NL, got);
        checks++;
        if (got != NL) begin errors++; $display("FAIL rstmid_count: got %0d outputs, required %0d", got, NL); end
        for (int k = 0; k < NL && obsq.size() > 0; k++) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            checks++;
            if (o.c1 !== e.c1 || o.c2 !== e.c2 || o.g !== e.g) begin
                errors++;
                $display("FAIL rstmid_line %0d: got %h/%h/%b, required %h/%h/%b", k, o.c1, o.c2, o.g, e.c1, e.c2, e.g);
            end
        end
        expq.delete();
        obsq.delete();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            cs_q[i] = int'(cs_r[i] * 1073741824.0);
            ca_q[i] = int'(ca_r[i] * 1073741824.0);
        end
        bus.ch1_in = '0;
        bus.ch2_in = '0;
        bus.gr_in = 1'b0;
        bus.window_switching_flag_in = 1'b0;
        bus.block_type_in = 2'd0;
        bus.mixed_block_flag_in = 1'b0;
        bus.din_v = 1'b0;

        test_reset();
        test_long();
        test_short();
        test_mixed();
        test_back_to_back();
        test_random();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
